alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values are 8 to 64, even.
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Reset  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 alu_src1  input  WIDTH  operand A.
REQ-007 alu_src2  input  WIDTH  operand B.
REQ-008 alu_ctr  input  4  operation select.
REQ-009 out_valid  output  1  result registers hold an unconsumed result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 alu_result  output  WIDTH  registered result.
REQ-012 zero_bit  output  1  1 when alu_result is all zeros.
REQ-013 overflow  output  1  signed overflow of ADD or SUB; 0 for every other operation.
REQ-014 illegal_op  output  1  the completed request carried an unassigned alu_ctr code.

Function
REQ-015 Acceptance: a request is accepted on a rising edge where in_valid=1 and in_ready=1; operands and alu_ctr are captured at that edge.
REQ-016 in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-017 Single-cycle opcodes (encoding: operation):
- 0000: AND
- 0001: OR
- 0010: ADD
- 0110: SUB
- 0111: SLT (signed; result 1 or 0)
- 1100: NOR
- 0011: XOR
REQ-018 Single-cycle opcodes have a latency of 1: out_valid rises on the edge that accepts the request.
REQ-019 Multi-cycle opcodes:
- 1000: MULU, low WIDTH bits of the unsigned product
- 1001: MULHU, high WIDTH bits of the unsigned product
- 1010: DIVU, unsigned quotient
- 1011: REMU, unsigned remainder
REQ-020 Multiplication is iterative shift-add and division is restoring, one bit per cycle; out_valid rises exactly WIDTH+1 edges after the accepting edge.
REQ-021 States:
- IDLE -> MUL on acceptance of opcode 1000 or 1001.
- IDLE -> DIV on acceptance of opcode 1010 or 1011.
- MUL or DIV -> IDLE when the iteration counter reaches WIDTH-1, loading the result registers on that same edge.
- Single-cycle and illegal opcodes stay in IDLE.
REQ-022 The iteration counter is $clog2(WIDTH) bits wide, cleared on acceptance, and incremented once per MUL/DIV cycle.
REQ-023 Divide by zero completes with normal latency: DIVU returns all ones, REMU returns alu_src1.
REQ-024 ADD and SUB wrap modulo 2^WIDTH.
REQ-025 overflow is set when both operands have the same sign and the result sign differs (ADD), or when the operand signs differ and the result sign differs from alu_src1 (SUB).
REQ-026 An unassigned alu_ctr code completes with latency 1: alu_result=0, zero_bit=1, illegal_op=1.
REQ-027 alu_result, zero_bit, overflow and illegal_op are registered, change only when new results load, and hold stable while out_valid=1 and out_ready=0.
REQ-028 out_valid clears on an edge with out_ready=1 unless a new result loads on that same edge, in which case it stays 1.
REQ-029 A single-cycle request may be accepted on the same edge the previous result is consumed, giving back-to-back results with no bubble.
REQ-030 A request is never accepted while MUL or DIV is active (in_ready=0); requests presented then are ignored and must be held by the source.
REQ-031 A multi-cycle result completing while out_valid=1 and out_ready=0 cannot occur, because acceptance requires an empty or draining output (REQ-016).

Reset
REQ-032 When Reset=1 at a rising edge:
- state goes to IDLE; counter and internal accumulators clear;
- out_valid=0, alu_result=0, zero_bit=1, overflow=0, illegal_op=0.
REQ-033 Reset takes precedence over acceptance, iteration and consumption on the same edge; an in-flight MUL/DIV is discarded with no result.
REQ-034 in_ready=1 on the first cycle after Reset deasserts.

Verification (WIDTH=32)
REQ-035 ADD 0x7FFFFFFF + 0x00000001 with out_ready=1 -> one edge later: out_valid=1, alu_result=0x80000000, overflow=1, zero_bit=0.
REQ-036 SUB 5 - 5 -> alu_result=0, zero_bit=1, overflow=0; SLT 0xFFFFFFFF vs 1 -> alu_result=1.
REQ-037 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> out_valid exactly 33 edges after acceptance, alu_result=0xFFFFFFFE; in_ready=0 throughout.
REQ-038 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles after an AND result -> outputs stable and in_ready=0; then out_ready=1 together with a new OR request -> out_valid stays 1 and the OR result appears next edge.
REQ-040 Assert Reset 10 cycles into a DIVU -> next edge out_valid=0, zero_bit=1; no result ever appears for that DIVU; a following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_mdu.sv
// ALU with an iterative multiply/divide unit behind a valid/ready handshake.
// Single-cycle ops return one edge after acceptance; MUL/DIV return WIDTH+1 edges after acceptance.
module alu_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  input  logic [3:0]       alu_ctr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_bit,
  output logic             overflow,
  output logic             illegal_op
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           r_state, w_state_d;
  logic [CW-1:0]    r_cnt;
  logic             r_fin;
  logic             r_hi_sel;
  logic [WIDTH-1:0] r_hi, r_lo, r_opb;
  logic             r_out_valid, r_zero, r_ovf, r_ill;
  logic [WIDTH-1:0] r_result;

  logic             w_accept, w_is_mul, w_is_div, w_mc_done, w_load, w_out_valid_d;
  logic [WIDTH-1:0] w_sum, w_diff, w_sc_res, w_mc_res, w_ld_res, w_div_sub;
  logic             w_sc_ovf, w_sc_ill;
  logic [WIDTH:0]   w_mul_sum, w_div_shift;
  logic             w_div_ge;

  // Single-cycle datapath and opcode decode.
  always_comb begin
    w_sum    = alu_src1 + alu_src2;
    w_diff   = alu_src1 - alu_src2;
    w_sc_res = '0;
    w_sc_ovf = 1'b0;
    w_sc_ill = 1'b0;
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    case (alu_ctr)
      4'b0000: w_sc_res = alu_src1 & alu_src2;
      4'b0001: w_sc_res = alu_src1 | alu_src2;
      4'b0011: w_sc_res = alu_src1 ^ alu_src2;
      4'b1100: w_sc_res = ~(alu_src1 | alu_src2);
      4'b0010: begin
        w_sc_res = w_sum;
        w_sc_ovf = (alu_src1[WIDTH-1] == alu_src2[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != alu_src1[WIDTH-1]);
      end
      4'b0110: begin
        w_sc_res = w_diff;
        w_sc_ovf = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != alu_src1[WIDTH-1]);
      end
      4'b0111: w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
      4'b1000, 4'b1001: w_is_mul = 1'b1;
      4'b1010, 4'b1011: w_is_div = 1'b1;
      default: w_sc_ill = 1'b1;
    endcase
  end

  // One shift-add (MUL) or restoring-subtract (DIV) step on {r_hi, r_lo}.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = w_div_shift >= {1'b0, r_opb};
    w_div_sub   = w_div_shift[WIDTH-1:0] - r_opb;
    w_mc_res    = r_hi_sel ? r_hi : r_lo;
  end

  // FSM: state register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // FSM: next state.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept && w_is_mul)      w_state_d = StMul;
        else if (w_accept && w_is_div) w_state_d = StDiv;
      end
      StMul, StDiv: if (r_fin) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // FSM: outputs and handshake.
  always_comb begin
    in_ready      = (r_state == StIdle) && (!r_out_valid || out_ready);
    w_accept      = in_valid && in_ready;
    w_mc_done     = (r_state != StIdle) && r_fin;
    w_load        = (w_accept && !w_is_mul && !w_is_div) || w_mc_done;
    w_ld_res      = w_mc_done ? w_mc_res : w_sc_res;
    w_out_valid_d = w_load ? 1'b1 : (out_ready ? 1'b0 : r_out_valid);
  end

  // Iteration datapath; r_fin adds the extra cycle that registers the final step.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_fin    <= 1'b0;
      r_hi_sel <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
    end else if (w_accept && (w_is_mul || w_is_div)) begin
      r_cnt    <= '0;
      r_fin    <= 1'b0;
      r_hi_sel <= alu_ctr[0];
      r_hi     <= '0;
      r_lo     <= alu_src1;
      r_opb    <= alu_src2;
    end else if ((r_state != StIdle) && !r_fin) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == LastCnt) r_fin <= 1'b1;
      if (r_state == StMul) begin
        r_hi <= w_mul_sum[WIDTH:1];
        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end else if (w_div_ge) begin
        r_hi <= w_div_sub;
        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        r_hi <= w_div_shift[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_d;
      if (w_load) begin
        r_result <= w_ld_res;
        r_zero   <= (w_ld_res == '0);
        r_ovf    <= w_mc_done ? 1'b0 : w_sc_ovf;
        r_ill    <= w_mc_done ? 1'b0 : w_sc_ill;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign zero_bit   = r_zero;
  assign overflow   = r_ovf;
  assign illegal_op = r_ill;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_src1 = '0;
  logic [31:0] alu_src2 = '0;
  logic [3:0]  alu_ctr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_result;
  logic        zero_bit, overflow, illegal_op;

  int checks = 0;
  int failures = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .alu_ctr   (alu_ctr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_result(alu_result),
    .zero_bit  (zero_bit),
    .overflow  (overflow),
    .illegal_op(illegal_op)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        ovf, ill;
  } vec_t;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present one request for a single edge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_ctr  = op;
    alu_src1 = a;
    alu_src2 = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid; note whether in_ready ever rose while waiting.
  task automatic wait_valid(output int cyc, output bit rdy_seen);
    cyc = 0;
    rdy_seen = 1'b0;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (out_valid) break;
      if (in_ready) rdy_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || alu_result !== 32'h0 || zero_bit !== 1'b1 ||
        overflow !== 1'b0 || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b r=%h z=%b o=%b i=%b, want v=0 r=0 z=1 o=0 i=0",
               out_valid, alu_result, zero_bit, overflow, illegal_op);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1;
    drive(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'h8000_0000 || overflow !== 1'b1 ||
        zero_bit !== 1'b0) begin
      failures++;
      $display("FAIL add_ovf: got v=%b r=%h o=%b z=%b, want v=1 r=80000000 o=1 z=0",
               out_valid, alu_result, overflow, zero_bit);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_consumed: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_alu_ops();
    vec_t v[13];
    v[0]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    v[1]  = '{4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0};
    v[2]  = '{4'b0011, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1'b0};
    v[3]  = '{4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    v[4]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
    v[5]  = '{4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
    v[6]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0};
    v[7]  = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
    v[8]  = '{4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0};
    v[9]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    v[10] = '{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
    v[11] = '{4'b0100, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b1};
    v[12] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if (out_valid !== 1'b1 || alu_result !== v[i].res || zero_bit !== (v[i].res == 32'h0) ||
          overflow !== v[i].ovf || illegal_op !== v[i].ill) begin
        failures++;
        $display("FAIL alu_vec%0d op=%b: got v=%b r=%h z=%b o=%b i=%b, want v=1 r=%h z=%b o=%b i=%b",
                 i, v[i].op, out_valid, alu_result, zero_bit, overflow, illegal_op,
                 v[i].res, (v[i].res == 32'h0), v[i].ovf, v[i].ill);
      end
    end
    tick();
  endtask

  task automatic test_mul_div();
    vec_t v[9];
    int   cyc;
    bit   rdy_seen;
    v[0] = '{4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0};
    v[1] = '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    v[2] = '{4'b1000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, 1'b0};
    v[3] = '{4'b1010, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0};
    v[4] = '{4'b1011, 32'd100,       32'd0,         32'd100,       1'b0, 1'b0};
    v[5] = '{4'b1010, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0};
    v[6] = '{4'b1011, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0};
    v[7] = '{4'b1010, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 1'b0, 1'b0};
    v[8] = '{4'b1011, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      wait_valid(cyc, rdy_seen);
      checks++;
      if (cyc !== 33 || rdy_seen) begin
        failures++;
        $display("FAIL md_latency%0d op=%b: got %0d edges in_ready_seen=%b, want 33 edges and 0",
                 i, v[i].op, cyc, rdy_seen);
      end
      checks++;
      if (alu_result !== v[i].res || overflow !== 1'b0 || illegal_op !== 1'b0 ||
          zero_bit !== 1'b0) begin
        failures++;
        $display("FAIL md_result%0d op=%b: got r=%h o=%b i=%b z=%b, want r=%h o=0 i=0 z=0",
                 i, v[i].op, alu_result, overflow, illegal_op, zero_bit, v[i].res);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || alu_result !== 32'hF000_F000 || zero_bit !== 1'b0 ||
          in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b r=%h z=%b rdy=%b, want v=1 r=f000f000 z=0 rdy=0",
                 i, out_valid, alu_result, zero_bit, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain_ready: got in_ready=%b want 1", in_ready);
    end
    drive(4'b0001, 32'h0000_000F, 32'h0000_00F0);
    checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL bp_next: got v=%b r=%h, want v=1 r=000000ff", out_valid, alu_result);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r[3];
    logic [31:0] a_v[3];
    logic [31:0] b_v[3];
    logic [3:0]  op_v[3];
    op_v = '{4'b0010, 4'b0010, 4'b0011};
    a_v  = '{32'd1, 32'd3, 32'hAAAA_5555};
    b_v  = '{32'd2, 32'd4, 32'hFFFF_0000};
    exp_r = '{32'd3, 32'd7, 32'h5555_5555};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_ctr  = op_v[i];
      alu_src1 = a_v[i];
      alu_src2 = b_v[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || alu_result !== exp_r[i]) begin
        failures++;
        $display("FAIL b2b%0d: got v=%b r=%h, want v=1 r=%h", i, out_valid, alu_result, exp_r[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_div();
    bit seen = 1'b0;
    out_ready = 1'b1;
    drive(4'b1010, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    Reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || zero_bit !== 1'b1 || alu_result !== 32'h0) begin
      failures++;
      $display("FAIL rst_div: got v=%b z=%b r=%h, want v=0 z=1 r=0", out_valid, zero_bit, alu_result);
    end
    Reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_div_ghost: got result_seen=%b want 0", seen);
    end
    drive(4'b0010, 32'd2, 32'd3);
    checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'd5) begin
      failures++;
      $display("FAIL rst_div_add: got v=%b r=%h, want v=1 r=00000005", out_valid, alu_result);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_alu_ops();
    test_mul_div();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
